// File: rtl/rd53_bgp_trim_sar_pkg.sv
// Shared types and parameter checks for the RD53 bandgap trim SAR controller.
package rd53_bgp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECIDE
  } bgp_sar_state_t;

  // True when the parameter set can be built: 1..8 trim bits, at least 3 settle
  // cycles (two go to the synchroniser), and a reset code that fits the trim word.
  function automatic bit params_ok(input int unsigned trim_w,
                                   input int unsigned settle_cyc,
                                   input int unsigned reset_code);
    return (trim_w >= 1) && (trim_w <= 8) && (settle_cyc >= 3) &&
           (reset_code < (32'd1 << trim_w));
  endfunction

endpackage

// File: rtl/rd53_bgp_trim_sar_if.sv
// Control/status bundle between the configuration side and the trim controller.
interface rd53_bgp_trim_sar_if #(
  parameter int unsigned TRIM_W = 5
);
  logic              start;
  logic              manual_load;
  logic [TRIM_W-1:0] manual_code;
  logic              cmp_hi;
  logic [TRIM_W-1:0] trim;
  logic              busy;
  logic              done;
  logic              locked;
  logic              err;

  modport master (
    output start, manual_load, manual_code, cmp_hi,
    input  trim, busy, done, locked, err
  );

  modport slave (
    input  start, manual_load, manual_code, cmp_hi,
    output trim, busy, done, locked, err
  );
endinterface

// File: rtl/rd53_bgp_cmp_sync.sv
// Two-flop synchroniser for the asynchronous bandgap comparator output.
module rd53_bgp_cmp_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  // Shift the comparator through two flops; synchronous reset clears both.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/rd53_bgp_trim_sar.sv
// Bandgap trim controller: holds the trim code and runs an MSB-first SAR search
// against the comparator, or loads a configuration word directly.
module rd53_bgp_trim_sar
  import rd53_bgp_pkg::*;
#(
  parameter int unsigned TRIM_W     = 5,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned RESET_CODE = 0
) (
  input logic               clk,
  input logic               rst,
  rd53_bgp_trim_sar_if.slave bus
);
  localparam int unsigned CW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned KW = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [TRIM_W-1:0] MsbCode = TRIM_W'(1) << (TRIM_W - 1);

  if (!params_ok(TRIM_W, SETTLE_CYC, RESET_CODE)) begin : g_param_check
    $fatal(1, "rd53_bgp_trim_sar: illegal TRIM_W/SETTLE_CYC/RESET_CODE");
  end

  bgp_sar_state_t    state_q;
  logic [CW-1:0]     cnt_q;
  logic [KW-1:0]     k_q;
  logic [TRIM_W-1:0] trim_q;
  logic              busy_q, done_q, locked_q, err_q;
  logic              cmp_sync;
  logic              cmp_bit;
  logic [TRIM_W-1:0] code_dec;

  rd53_bgp_cmp_sync u_cmp_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.cmp_hi),
    .q   (cmp_sync)
  );

  // An undriven comparator resolves to 1, which steps the trim down (lower VREF).
  assign cmp_bit = (cmp_sync === 1'b0) ? 1'b0 : 1'b1;

  // Code after resolving bit k: clear it if VREF is high, then raise the next trial bit.
  always_comb begin
    code_dec = trim_q;
    code_dec[k_q] = trim_q[k_q] & ~cmp_bit;
    if (k_q != '0) code_dec[k_q - KW'(1)] = 1'b1;
  end

  // SAR FSM, settle counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      trim_q   <= TRIM_W'(RESET_CODE);
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.manual_load) begin
        // Manual load aborts any search silently and wins over START.
        state_q  <= IDLE;
        cnt_q    <= '0;
        trim_q   <= bus.manual_code;
        busy_q   <= 1'b0;
        locked_q <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.start) begin
              state_q  <= SETTLE;
              cnt_q    <= '0;
              k_q      <= KW'(TRIM_W - 1);
              trim_q   <= MsbCode;
              busy_q   <= 1'b1;
              locked_q <= 1'b0;
              err_q    <= 1'b0;
            end
          end
          SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYC - 1)) begin
              cnt_q   <= '0;
              state_q <= DECIDE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          DECIDE: begin
            trim_q <= code_dec;
            if (k_q != '0) begin
              k_q     <= k_q - KW'(1);
              state_q <= SETTLE;
            end else begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              locked_q <= 1'b1;
              err_q    <= (code_dec == '0) || (&code_dec);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Flag a comparator that is not driven to a clean level when it is used.
  always_ff @(posedge clk) begin
    if (!rst && state_q == DECIDE) assert (!$isunknown(cmp_sync));
  end

  assign bus.trim   = trim_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.locked = locked_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_rd53_bgp_trim_sar.sv
// Directed bench for rd53_bgp_trim_sar: default build with RESET_CODE=7 and an
// 8-bit, 3-cycle-settle build, each against a threshold comparator model.
module tb_rd53_bgp_trim_sar;
  logic clk;
  logic rst0, rst1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cmp_mode0 = 2;  // 0: tied low, 1: tied high, 2: trim > thr0
  int   thr0 = 19;
  logic [4:0] hist0 [0:255];

  rd53_bgp_trim_sar_if #(.TRIM_W(5)) if0 ();
  rd53_bgp_trim_sar_if #(.TRIM_W(8)) if1 ();

  rd53_bgp_trim_sar #(.TRIM_W(5), .SETTLE_CYC(16), .RESET_CODE(7)) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (if0.slave)
  );

  rd53_bgp_trim_sar #(.TRIM_W(8), .SETTLE_CYC(3), .RESET_CODE(90)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1.slave)
  );

  // Comparator models: VREF rises with the code, target sits at the threshold.
  assign if0.cmp_hi = (cmp_mode0 == 2) ? (32'(if0.trim) > thr0) : (cmp_mode0 == 1);
  assign if1.cmp_hi = (if1.trim > 8'd200);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse START on dut0 (edge 0), optionally pulse it again before edge restart_at,
  // and return the edge number of the first DONE (-1 if it never came).
  task automatic search0(input int restart_at, output int done_edge);
    done_edge = -1;
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    hist0[0] = if0.trim;
    for (int e = 1; e <= 200; e++) begin
      if (e == restart_at) if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      hist0[e] = if0.trim;
      if (if0.done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  task automatic search1(output int done_edge);
    done_edge = -1;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (if1.done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  initial begin
    int de;
    int seen;
    if0.start = 1'b0; if0.manual_load = 1'b0; if0.manual_code = '0;
    if1.start = 1'b0; if1.manual_load = 1'b0; if1.manual_code = '0;
    rst0 = 1'b1;
    rst1 = 1'b1;

    // Reset with a toggling comparator.
    for (int i = 0; i < 3; i++) begin
      cmp_mode0 = i % 2;
      tick();
    end
    check_eq("rst_trim", 32'(if0.trim), 7);
    check_eq("rst_busy", 32'(if0.busy), 0);
    check_eq("rst_done", 32'(if0.done), 0);
    check_eq("rst_locked", 32'(if0.locked), 0);
    check_eq("rst_err", 32'(if0.err), 0);
    check_eq("rst1_trim", 32'(if1.trim), 90);
    rst0 = 1'b0;
    rst1 = 1'b0;
    cmp_mode0 = 2;
    tick();
    tick();

    // Nominal search, threshold 19.
    search0(0, de);
    check_eq("nom_trial0", 32'(hist0[0]), 16);
    check_eq("nom_trial1", 32'(hist0[17]), 24);
    check_eq("nom_trial2", 32'(hist0[34]), 20);
    check_eq("nom_trial3", 32'(hist0[51]), 18);
    check_eq("nom_trial4", 32'(hist0[68]), 19);
    check_eq("nom_done_edge", 32'(de), 85);
    check_eq("nom_trim", 32'(if0.trim), 19);
    check_eq("nom_locked", 32'(if0.locked), 1);
    check_eq("nom_err", 32'(if0.err), 0);
    check_eq("nom_busy", 32'(if0.busy), 0);
    tick();
    check_eq("nom_done_low", 32'(if0.done), 0);

    // Saturation both ways.
    cmp_mode0 = 0;
    tick();
    tick();
    search0(0, de);
    check_eq("sat_hi_edge", 32'(de), 85);
    check_eq("sat_hi_trim", 32'(if0.trim), 31);
    check_eq("sat_hi_err", 32'(if0.err), 1);
    cmp_mode0 = 1;
    tick();
    tick();
    search0(0, de);
    check_eq("sat_lo_trim", 32'(if0.trim), 0);
    check_eq("sat_lo_err", 32'(if0.err), 1);
    cmp_mode0 = 2;
    tick();
    tick();

    // Abort with MANUAL_LOAD at edge 40.
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int e = 1; e <= 39; e++) tick();
    check_eq("abort_busy_before", 32'(if0.busy), 1);
    if0.manual_load = 1'b1;
    if0.manual_code = 5'd5;
    tick();
    if0.manual_load = 1'b0;
    check_eq("abort_trim", 32'(if0.trim), 5);
    check_eq("abort_busy", 32'(if0.busy), 0);
    check_eq("abort_locked", 32'(if0.locked), 0);
    check_eq("abort_err", 32'(if0.err), 0);
    seen = 0;
    for (int e = 0; e < 60; e++) begin
      tick();
      if (if0.done) seen++;
    end
    check_eq("abort_no_done", 32'(seen), 0);
    check_eq("abort_trim_hold", 32'(if0.trim), 5);

    // START and MANUAL_LOAD together: load only.
    if0.start = 1'b1;
    if0.manual_load = 1'b1;
    if0.manual_code = 5'd9;
    tick();
    if0.start = 1'b0;
    if0.manual_load = 1'b0;
    check_eq("coll_trim", 32'(if0.trim), 9);
    check_eq("coll_busy", 32'(if0.busy), 0);
    seen = 0;
    for (int e = 0; e < 100; e++) begin
      tick();
      if (if0.done) seen++;
    end
    check_eq("coll_no_done", 32'(seen), 0);
    check_eq("coll_trim_hold", 32'(if0.trim), 9);

    // START while busy is ignored.
    search0(20, de);
    check_eq("restart_done_edge", 32'(de), 85);
    check_eq("restart_trim", 32'(if0.trim), 19);

    // 8-bit build, threshold 200.
    search1(de);
    check_eq("p8_done_edge", 32'(de), 32);
    check_eq("p8_trim", 32'(if1.trim), 200);
    check_eq("p8_locked", 32'(if1.locked), 1);
    check_eq("p8_err", 32'(if1.err), 0);
    tick();

    // RST at edge 10 of a search.
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int e = 1; e <= 9; e++) tick();
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    check_eq("p8_rst_trim", 32'(if1.trim), 90);
    check_eq("p8_rst_busy", 32'(if1.busy), 0);
    check_eq("p8_rst_locked", 32'(if1.locked), 0);
    check_eq("p8_rst_done", 32'(if1.done), 0);
    tick();
    // A clean search afterwards shows the FSM restarted from IDLE.
    search1(de);
    check_eq("p8_after_rst_edge", 32'(de), 32);
    check_eq("p8_after_rst_trim", 32'(if1.trim), 200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rd53_bgp_trim_sar.md
# rd53_bgp_trim_sar

Parametrised trim controller for the RD53 bandgap voltage references. It holds the trim code driven onto the bandgap trim inputs (B0..B<n>) and loads it either directly from configuration or by an on-chip successive-approximation (SAR) search. The search drives a comparator that checks VREF against an external target. The block sits between the global configuration registers and the bandgap macro, and replaces a static trim word with a self-calibrating one of configurable width and settling time.

## Interface
Parameters:
- TRIM_W, 5, trim code width; legal range 1..8.
- SETTLE_CYC, 16, number of settle cycles per SAR bit before the comparator is sampled; minimum 3.
- RESET_CODE, 0, trim code applied at reset.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle pulse that begins a SAR search.
- MANUAL_LOAD  in  1  single-cycle pulse that loads MANUAL_CODE into TRIM.
- MANUAL_CODE  in  TRIM_W  configuration trim word.
- CMP_HI  in  1  asynchronous comparator output; 1 means VREF is above target.
- TRIM  out  TRIM_W  trim code for the bandgap macro; higher code gives higher VREF.
- BUSY  out  1  high while a search is in progress.
- DONE  out  1  single-cycle pulse when a search completes.
- LOCKED  out  1  high while TRIM holds a completed search result.
- ERR  out  1  last search saturated at code 0 or code 2^TRIM_W-1.

## Operation
- States:
  - IDLE: no search active.
  - SETTLE: the trial code is applied; the settle counter runs for SETTLE_CYC cycles.
  - DECIDE: one cycle in which the current bit is resolved.
- IDLE to SETTLE, on START with MANUAL_LOAD low:
  - TRIM is set to MSB=1, all other bits 0.
  - Bit index k = TRIM_W-1.
  - LOCKED and ERR are cleared and BUSY is set.
- SETTLE to DECIDE when the counter expires after SETTLE_CYC cycles.
- DECIDE, using the synchronised CMP_HI:
  - If CMP_HI=1, bit k is cleared; otherwise bit k is kept.
  - If k>0, bit k-1 is set, k is decremented and the state returns to SETTLE.
  - If k=0, the state returns to IDLE: DONE pulses, LOCKED=1, BUSY=0, and ERR=1 if the result is all-zeros or all-ones.
- The result is the largest code for which CMP_HI=0, assuming a monotonic response.
- CMP_HI passes through a 2-flop synchroniser. An X/Z value sampled in DECIDE is treated as 1 (the safe, lower-voltage choice), and a simulation assertion fires.
- MANUAL_LOAD in any state:
  - Next edge: TRIM=MANUAL_CODE, state=IDLE, BUSY=0, LOCKED=0, ERR=0.
  - No DONE pulse is issued, so a search is aborted silently.
- START and MANUAL_LOAD in the same cycle: MANUAL_LOAD wins and START is dropped.
- START while BUSY is ignored and does not restart the search.
- RST has priority over everything.
  - Next edge: TRIM=RESET_CODE, state=IDLE, counter=0, synchroniser cleared, BUSY=0, DONE=0, LOCKED=0, ERR=0.
  - This applies mid-search as well.
- The settle counter width is $clog2(SETTLE_CYC+1). The bit index width is $clog2(TRIM_W), minimum 1.
- Illegal parameters cause an elaboration-time fatal error.

## Timing
- TRIM, BUSY, DONE, LOCKED and ERR are all registered; there are no combinational paths from input to output.
- Numbering the edge that samples START as edge 0:
  - The first trial code is visible after edge 0.
  - Each bit takes SETTLE_CYC+1 cycles.
  - DONE is high after edge TRIM_W*(SETTLE_CYC+1) and low one edge later.
  - With the defaults this is edge 85.
- CMP_HI must be stable at least 2 cycles before the DECIDE edge, which covers the synchroniser latency. This is why SETTLE_CYC ≥ 3.
- MANUAL_LOAD sampled at edge n gives TRIM=MANUAL_CODE after edge n.

## Structure
- Package rd53_bgp_pkg holds:
  - the state enum bgp_sar_state_t {IDLE, SETTLE, DECIDE};
  - the parameter-legality check function.
- Sub-module rd53_bgp_cmp_sync is the 2-flop synchroniser with synchronous reset. It is instantiated once.
- The FSM, counter and code register live in the top module.

## Test plan
- Reset: assert RST for 3 cycles with RESET_CODE=7 -> TRIM=7 and all flags 0; CMP_HI toggling has no effect.
- Nominal search with defaults: bench model CMP_HI = (TRIM > 19) -> trial sequence 16, 24, 20, 18, 19; DONE at edge 85; TRIM=19; LOCKED=1; ERR=0.
- Saturation:
  - CMP_HI tied to 0 -> TRIM=31, ERR=1.
  - CMP_HI tied to 1 -> TRIM=0, ERR=1.
- Abort: MANUAL_LOAD with MANUAL_CODE=5 at edge 40 of a search -> TRIM=5 after edge 40, BUSY=0, no DONE, LOCKED=0.
- Collisions:
  - START and MANUAL_LOAD in the same cycle -> manual load only.
  - START while BUSY -> ignored; DONE still arrives at edge 85 of the original search.
- Parametrisation: TRIM_W=8, SETTLE_CYC=3, threshold 200 -> TRIM=200 and DONE at edge 32. RST at edge 10 -> TRIM=RESET_CODE and the FSM is in IDLE.
